onchip_memory_arbiter: RTL and testbench

Two-port round-robin arbiter that shares the single-port 1024×32 on-chip RAM between two Avalon-MM requesters: port 0 is the Nios II data master, port 1 is the sprite/DMA engine. It sits between the requesters and the RAM's s1 slave. It issues at most one RAM access per cycle and returns read data through a one-deep pending-read tracker. The RAM's read latency is one clock: address is registered, q is unregistered.

---
 rtl/onchip_memory_arbiter.sv | 104 ++++++++++
 tb/tb_onchip_memory_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/onchip_memory_arbiter.sv
// Two-port round-robin arbiter sharing a single-port on-chip RAM between two
// Avalon-MM requesters, with a one-deep pending-read tracker for returns.
module onchip_memory_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_W-1:0]     m0_address,
  input  logic [DATA_W/8-1:0]   m0_byteenable,
  input  logic                  m0_read,
  input  logic                  m0_write,
  input  logic [DATA_W-1:0]     m0_writedata,
  output logic                  m0_waitrequest,
  output logic [DATA_W-1:0]     m0_readdata,
  output logic                  m0_readdatavalid,
  input  logic [ADDR_W-1:0]     m1_address,
  input  logic [DATA_W/8-1:0]   m1_byteenable,
  input  logic                  m1_read,
  input  logic                  m1_write,
  input  logic [DATA_W-1:0]     m1_writedata,
  output logic                  m1_waitrequest,
  output logic [DATA_W-1:0]     m1_readdata,
  output logic                  m1_readdatavalid,
  output logic [ADDR_W-1:0]     mem_address,
  output logic [DATA_W/8-1:0]   mem_byteenable,
  output logic                  mem_chipselect,
  output logic                  mem_write,
  output logic [DATA_W-1:0]     mem_writedata,
  output logic                  mem_clken,
  input  logic [DATA_W-1:0]     mem_readdata
);

  logic              req0, req1;
  logic              gnt0, gnt1, any_gnt;
  logic              sel_read, sel_write;
  logic              last_q, last_d;
  logic              rd_pend_q, rd_pend_d;
  logic              rd_owner_q, rd_owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  // Grant: a lone requester wins; under contention the port not in last wins.
  always_comb begin
    req0 = m0_read | m0_write;
    req1 = m1_read | m1_write;
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset) begin
      if (req0 && req1) begin
        gnt0 = last_q;
        gnt1 = ~last_q;
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
    any_gnt = gnt0 | gnt1;
  end

  always_comb begin
    sel_read  = gnt1 ? m1_read  : m0_read;
    sel_write = gnt1 ? m1_write : m0_write;

    last_d     = any_gnt ? gnt1 : last_q;
    // A simultaneous read+write performs only the write.
    rd_pend_d  = any_gnt & sel_read & ~sel_write;
    rd_owner_d = rd_pend_d ? gnt1 : rd_owner_q;
    addr_d     = any_gnt ? (gnt1 ? m1_address : m0_address) : addr_q;
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q     <= 1'b1;
      rd_pend_q  <= 1'b0;
      rd_owner_q <= 1'b0;
      addr_q     <= '0;
    end else begin
      last_q     <= last_d;
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
      addr_q     <= addr_d;
    end
  end

  always_comb begin
    mem_chipselect = any_gnt;
    mem_write      = any_gnt & sel_write;
    mem_address    = addr_d;
    mem_byteenable = gnt1 ? m1_byteenable : m0_byteenable;
    mem_writedata  = gnt1 ? m1_writedata  : m0_writedata;
    mem_clken      = ~reset;

    m0_waitrequest = reset | (req0 & ~gnt0);
    m1_waitrequest = reset | (req1 & ~gnt1);

    m0_readdata      = mem_readdata;
    m1_readdata      = mem_readdata;
    m0_readdatavalid = rd_pend_q & ~rd_owner_q;
    m1_readdatavalid = rd_pend_q &  rd_owner_q;
  end

endmodule

// File: tb/tb_onchip_memory_arbiter.sv
// Directed bench for onchip_memory_arbiter with a behavioural 1-cycle-latency
// RAM model attached to the mem_* side.
module tb_onchip_memory_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  m0_address, m1_address;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [31:0] m0_writedata, m1_writedata;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic [9:0]  mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect, mem_write, mem_clken;
  logic [31:0] mem_writedata, mem_readdata;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  onchip_memory_arbiter #(.ADDR_W(10), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable),
    .m0_read(m0_read), .m0_write(m0_write), .m0_writedata(m0_writedata),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable),
    .m1_read(m1_read), .m1_write(m1_write), .m1_writedata(m1_writedata),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_clken(mem_clken),
    .mem_readdata(mem_readdata)
  );

  // RAM model: registered address, unregistered q, byte-lane writes.
  logic [31:0] ram [0:1023];
  logic [9:0]  ram_addr_q = '0;

  always @(posedge clk) begin
    if (mem_clken && mem_chipselect) begin
      if (mem_write)
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      ram_addr_q <= mem_address;
    end
  end

  assign mem_readdata = ram[ram_addr_q];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic idle();
    m0_read = 1'b0; m0_write = 1'b0;
    m1_read = 1'b0; m1_write = 1'b0;
  endtask

  initial begin
    int k0, k1, nv0, nv1, owner;
    logic [31:0] exp;

    for (int i = 0; i < 1024; i++) ram[i] = '0;
    ram[10'h005] = 32'h1234_5678;
    for (int i = 0; i < 8; i++) ram[10'h020 + i] = 32'hC0DE_0020 + i;

    reset = 1'b1;
    m0_address = '0; m1_address = '0;
    m0_byteenable = 4'hF; m1_byteenable = 4'hF;
    m0_writedata = '0; m1_writedata = '0;
    idle();
    m0_read = 1'b1;
    m1_write = 1'b1;

    // Reset state, with requests present to show they are ignored.
    repeat (2) @(posedge clk);
    #1;
    check("rst_wait0", m0_waitrequest, 1);
    check("rst_wait1", m1_waitrequest, 1);
    check("rst_cs", mem_chipselect, 0);
    check("rst_wr", mem_write, 0);
    check("rst_clken", mem_clken, 0);
    check("rst_rdv0", m0_readdatavalid, 0);
    check("rst_rdv1", m1_readdatavalid, 0);

    // Single read, granted in the first cycle after reset release.
    @(negedge clk);
    reset = 1'b0;
    idle();
    m0_read = 1'b1; m0_address = 10'h005;
    #1;
    check("sr_wait0", m0_waitrequest, 0);
    check("sr_wait1_idle", m1_waitrequest, 0);
    check("sr_cs", mem_chipselect, 1);
    check("sr_addr", mem_address, 10'h005);
    check("sr_clken", mem_clken, 1);
    @(posedge clk); #1;
    check("sr_rdv0", m0_readdatavalid, 1);
    check("sr_data", m0_readdata, 32'h1234_5678);
    check("sr_rdv1", m1_readdatavalid, 0);
    @(negedge clk); idle();

    // Contending writes straight out of reset: port 0 then port 1.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m0_write = 1'b1; m0_address = 10'h010; m0_writedata = 32'hAAAA_AAAA; m0_byteenable = 4'hF;
    m1_write = 1'b1; m1_address = 10'h011; m1_writedata = 32'h5555_5555; m1_byteenable = 4'hF;
    #1;
    check("ct0_wait0", m0_waitrequest, 0);
    check("ct0_wait1", m1_waitrequest, 1);
    check("ct0_addr", mem_address, 10'h010);
    check("ct0_wdata", mem_writedata, 32'hAAAA_AAAA);
    check("ct0_wr", mem_write, 1);
    @(posedge clk); #1;
    check("ct0_no_rdv", m0_readdatavalid, 0);
    @(negedge clk);
    m0_write = 1'b0;
    #1;
    check("ct1_wait1", m1_waitrequest, 0);
    check("ct1_addr", mem_address, 10'h011);
    check("ct1_wdata", mem_writedata, 32'h5555_5555);
    @(negedge clk);
    idle();
    m0_read = 1'b1; m0_address = 10'h010;
    @(posedge clk); #1;
    check("ct_rb0_rdv", m0_readdatavalid, 1);
    check("ct_rb0_data", m0_readdata, 32'hAAAA_AAAA);
    @(negedge clk);
    idle();
    m1_read = 1'b1; m1_address = 10'h011;
    @(posedge clk); #1;
    check("ct_rb1_rdv", m1_readdatavalid, 1);
    check("ct_rb1_data", m1_readdata, 32'h5555_5555);
    @(negedge clk); idle();

    // Continuous dual reads; last grant went to port 1, so port 0 leads.
    k0 = 0; k1 = 0; nv0 = 0; nv1 = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      m0_read = 1'b1; m0_address = 10'h020 + 10'(k0);
      m1_read = 1'b1; m1_address = 10'h024 + 10'(k1);
      owner = i % 2;
      #1;
      check("dr_wait0", m0_waitrequest, (owner != 0));
      check("dr_wait1", m1_waitrequest, (owner != 1));
      @(posedge clk); #1;
      check("dr_rdv0", m0_readdatavalid, (owner == 0));
      check("dr_rdv1", m1_readdatavalid, (owner == 1));
      check("dr_one_valid", m0_readdatavalid & m1_readdatavalid, 0);
      if (m0_readdatavalid) nv0++;
      if (m1_readdatavalid) nv1++;
      if (owner == 0) begin
        check("dr_data0", m0_readdata, 32'hC0DE_0020 + k0);
        k0++;
      end else begin
        check("dr_data1", m1_readdata, 32'hC0DE_0024 + k1);
        k1++;
      end
    end
    @(negedge clk); idle();
    check("dr_count0", nv0, 4);
    check("dr_count1", nv1, 4);

    // Byte-lane write into a zero word.
    m1_write = 1'b1; m1_address = 10'h040; m1_byteenable = 4'b0010; m1_writedata = 32'hFFFF_FFFF;
    @(negedge clk);
    idle();
    m1_read = 1'b1; m1_address = 10'h040;
    @(posedge clk); #1;
    check("bw_rdv1", m1_readdatavalid, 1);
    check("bw_data", m1_readdata, 32'h0000_FF00);
    @(negedge clk); idle();

    // Write then read the same address on consecutive cycles.
    m0_write = 1'b1; m0_address = 10'h3FF; m0_byteenable = 4'hF; m0_writedata = 32'hDEAD_BEEF;
    @(negedge clk);
    m0_write = 1'b0; m0_read = 1'b1;
    @(posedge clk); #1;
    exp = 32'hDEAD_BEEF;
    check("wr_rd_rdv0", m0_readdatavalid, 1);
    check("wr_rd_data", m0_readdata, exp);
    @(negedge clk); idle();

    // Reset right after a read is accepted: the return must be dropped.
    m0_read = 1'b1; m0_address = 10'h005;
    @(posedge clk);
    #1;
    reset = 1'b1;
    m1_read = 1'b1; m1_address = 10'h020;
    #1;
    check("mr_rdv0", m0_readdatavalid, 0);
    check("mr_rdv1", m1_readdatavalid, 0);
    check("mr_wait0", m0_waitrequest, 1);
    check("mr_wait1", m1_waitrequest, 1);
    @(posedge clk); #1;
    check("mr_rdv0_held", m0_readdatavalid, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("mr_post_wait0", m0_waitrequest, 0);
    check("mr_post_wait1", m1_waitrequest, 1);
    @(posedge clk); #1;
    check("mr_post_rdv0", m0_readdatavalid, 1);
    check("mr_post_data", m0_readdata, 32'h1234_5678);
    @(negedge clk); idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
